quad_decoder_counter: RTL

//  Decodes a 2-phase quadrature input (A/B from a rotary or linear encoder) into
//  up/down count steps. Accumulates a wrapping WIDTH-bit position counter.

---
 rtl/quad_decoder_counter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/quad_decoder_counter.sv
// Quadrature A/B decoder with x4 resolution driving a wrapping up/down position counter.
// Inputs are synchronized, primed after reset, then compared cycle-to-cycle for step/error detection.
module quad_decoder_counter #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             cnt_en,
    input  logic             clear,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             step,
    output logic             err
);

    typedef enum logic {PRIME, RUN} state_t;

    localparam int PW = $clog2(SYNC_STAGES + 2);

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic [1:0]             cur;
    logic [1:0]             prev;
    logic [1:0]             delta;
    logic [PW-1:0]          prime_cnt;
    state_t                 state;
    state_t                 state_next;
    logic                   legal_up;
    logic                   legal_down;
    logic                   illegal;

    // Position of a phase pair along the up sequence 00->10->11->01.
    function automatic logic [1:0] phase_pos(input logic [1:0] ab);
        logic [1:0] pos;
        case (ab)
            2'b00:   pos = 2'd0;
            2'b10:   pos = 2'd1;
            2'b11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

    function automatic logic [WIDTH-1:0] wrap_step(input logic [WIDTH-1:0] val,
                                                   input logic up);
        return up ? val + 1'b1 : val - 1'b1;
    endfunction

    assign cur = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_sync <= '0;
            b_sync <= '0;
            prev   <= 2'b00;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], a_in};
            b_sync <= {b_sync[SYNC_STAGES-2:0], b_in};
            prev   <= cur;
        end
    end

    // Priming spans SYNC_STAGES+1 edges so prev has latched the settled synchronizer
    // output before the first comparison in RUN.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= PRIME;
            prime_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == PRIME && prime_cnt != PW'(SYNC_STAGES)) begin
                prime_cnt <= prime_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        legal_up   = 1'b0;
        legal_down = 1'b0;
        illegal    = 1'b0;
        delta      = phase_pos(cur) - phase_pos(prev);
        case (state)
            PRIME: begin
                if (prime_cnt == PW'(SYNC_STAGES)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                legal_up   = (delta == 2'd1);
                legal_down = (delta == 2'd3);
                illegal    = (delta == 2'd2);
            end
            default: state_next = PRIME;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q    <= '0;
            dir  <= 1'b0;
            step <= 1'b0;
        end else begin
            step <= 1'b0;
            if (clear) begin
                q <= '0;
            end else if (cnt_en && (legal_up || legal_down)) begin
                q    <= wrap_step(q, legal_up);
                dir  <= legal_up;
                step <= 1'b1;
            end
        end
    end

    // A new illegal transition outranks err_clr so no error is lost.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            err <= 1'b0;
        end else if (illegal) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule
